// File: rtl/pair_det_sched.sv
// Round-robin scheduler sharing one external 1-bit pair detector among NREQ requesters.
// Define PAIR_DET_SCHED_PRIO_EN to grant the lowest-index valid requester instead of round-robin.
module pair_det_sched #(
    parameter int NREQ   = 4,
    parameter int WORD_W = 8,
    parameter int CNT_W  = 4,
    parameter int ID_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*WORD_W-1:0] i_req_data,
    output logic [NREQ-1:0]        o_req_ready,
    output logic                   o_det_rst,
    output logic                   o_det_in,
    input  logic                   i_det_out,
    output logic                   o_rsp_valid,
    output logic [ID_W-1:0]        o_rsp_id,
    output logic [CNT_W-1:0]       o_rsp_count,
    input  logic                   i_rsp_ready
);
    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [NREQ-1:0] REQ_ONE = NREQ'(1);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, RESP} state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_shreg;
    logic [IDX_W-1:0]  r_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic [ID_W-1:0]   r_id;
    logic              r_detIn;
    logic              r_rspValid;
    logic [ID_W-1:0]   r_rspId;
    logic [CNT_W-1:0]  r_rspCount;

    logic              w_grantValid;
    logic [ID_W-1:0]   w_grantIdx;
    logic [WORD_W-1:0] w_grantData;

`ifdef PAIR_DET_SCHED_PRIO_EN
    // Descending scan so the lowest valid index is the last (winning) assignment.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (i_req_valid[k]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = ID_W'(k);
            end
        end
    end
`else
    logic [ID_W-1:0] r_rrPtr;
    logic [ID_W-1:0] w_cand;

    function automatic logic [ID_W-1:0] wrapIdx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NREQ) s = s - NREQ;
        return ID_W'(s);
    endfunction

    // Scan offsets NREQ..1 so the nearest requester after r_rrPtr wins.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_cand       = '0;
        for (int k = NREQ; k >= 1; k--) begin
            w_cand = wrapIdx(int'(r_rrPtr), k);
            if (i_req_valid[w_cand]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = w_cand;
            end
        end
    end
`endif

    assign w_grantData = i_req_data[w_grantIdx*WORD_W +: WORD_W];

    // The accept pulse must coincide with the grant decision, so it is decoded from IDLE.
    assign o_req_ready = (r_state == IDLE && !reset && w_grantValid) ? (REQ_ONE << w_grantIdx) : '0;
    assign o_det_rst   = reset || (r_state == CLR);
    assign o_det_in    = r_detIn;
    assign o_rsp_valid = r_rspValid;
    assign o_rsp_id    = r_rspId;
    assign o_rsp_count = r_rspCount;

    // r_shreg is pre-shifted so r_detIn always presents the next MSB during SHIFT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_id       <= '0;
            r_detIn    <= 1'b0;
            r_rspValid <= 1'b0;
            r_rspId    <= '0;
            r_rspCount <= '0;
`ifndef PAIR_DET_SCHED_PRIO_EN
            r_rrPtr    <= ID_W'(NREQ - 1);
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grantValid) begin
                        r_shreg <= w_grantData;
                        r_id    <= w_grantIdx;
                        r_cnt   <= '0;
                        r_state <= CLR;
                    end
                end
                CLR: begin
                    r_idx   <= '0;
                    r_detIn <= r_shreg[WORD_W-1];
                    r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    r_cnt <= r_cnt + CNT_W'(i_det_out);
                    if (r_idx == IDX_W'(WORD_W - 1)) begin
                        r_detIn <= 1'b0;
                        r_state <= DRAIN;
                    end else begin
                        r_idx   <= r_idx + IDX_W'(1);
                        r_detIn <= r_shreg[WORD_W-1];
                        r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
                    end
                end
                DRAIN: begin
                    r_rspCount <= r_cnt + CNT_W'(i_det_out);
                    r_rspId    <= r_id;
                    r_rspValid <= 1'b1;
                    r_state    <= RESP;
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        r_rspValid <= 1'b0;
`ifndef PAIR_DET_SCHED_PRIO_EN
                        r_rrPtr    <= r_id;
`endif
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pair_det_sched.sv
// Scoreboard bench for pair_det_sched: random requests checked against a word-level pair-count model.
// Includes a behavioural model of the external pair detector.
module tb_pair_det_sched;
    localparam int NREQ   = 4;
    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;
    localparam int ID_W   = 2;

    logic                   clk;
    logic                   reset;
    logic [NREQ-1:0]        reqValid;
    logic [NREQ*WORD_W-1:0] reqData;
    logic [NREQ-1:0]        reqReady;
    logic                   detRst;
    logic                   detIn;
    logic                   detOut;
    logic                   rspValid;
    logic [ID_W-1:0]        rspId;
    logic [CNT_W-1:0]       rspCount;
    logic                   rspReady;

    pair_det_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .CNT_W(CNT_W), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(reqValid), .i_req_data(reqData), .o_req_ready(reqReady),
        .o_det_rst(detRst), .o_det_in(detIn), .i_det_out(detOut),
        .o_rsp_valid(rspValid), .o_rsp_id(rspId), .o_rsp_count(rspCount),
        .i_rsp_ready(rspReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External pair detector: high once two sampled bits exist and the last two match.
    logic [1:0] detSeen;
    logic       detLast, detPrev;
    always @(posedge clk) begin
        if (detRst) begin
            detSeen <= 2'd0;
            detLast <= 1'b0;
            detPrev <= 1'b0;
        end else begin
            detPrev <= detLast;
            detLast <= detIn;
            if (detSeen != 2'd2) detSeen <= detSeen + 2'd1;
        end
    end
    assign detOut = (detSeen == 2'd2) && (detLast == detPrev);

    typedef struct {
        int id;
        int count;
    } expT;

    expT  expQ[$];
    expT  e;
    int   total = 0;
    int   bad = 0;
    int   cycleCount = 0;
    int   grantCycle = 0;
    int   modelPtr = NREQ - 1;
    bit   modelBusy = 1'b0;
    bit   wasReset = 1'b0;
    bit   prevHold = 1'b0;
    int   prevId, prevCount;
    int   protoPhase = -1;
    logic [WORD_W-1:0] protoWord;
    logic [WORD_W-1:0] grantWord;
    int   g, expReady;

    function automatic int pairCount(input logic [WORD_W-1:0] w);
        int n = 0;
        for (int i = 1; i < WORD_W; i++) if (w[i] == w[i-1]) n++;
        return n;
    endfunction

    function automatic int pickGrant(input logic [NREQ-1:0] v, input int ptr);
`ifdef PAIR_DET_SCHED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
`else
        for (int off = 1; off <= NREQ; off++) if (v[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
`endif
        return -1;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cycleCount);
        end
    endtask

    // Monitor: derives expected grants and responses from the model and compares DUT outputs.
    always @(negedge clk) begin
        cycleCount++;
        if (reset) begin
            checkOutput("detRstInReset", int'(detRst), 1);
            checkOutput("reqReadyInReset", int'(reqReady), 0);
            expQ.delete();
            modelBusy  = 1'b0;
            modelPtr   = NREQ - 1;
            protoPhase = -1;
            prevHold   = 1'b0;
            wasReset   = 1'b1;
        end else begin
            if (wasReset) begin
                checkOutput("resetRspValid", int'(rspValid), 0);
                checkOutput("resetRspId", int'(rspId), 0);
                checkOutput("resetRspCount", int'(rspCount), 0);
                checkOutput("resetDetIn", int'(detIn), 0);
                wasReset = 1'b0;
            end
            if (protoPhase == 0) begin
                checkOutput("detRstClr", int'(detRst), 1);
                protoPhase = 1;
            end else if (protoPhase > 0) begin
                checkOutput("detRstShift", int'(detRst), 0);
                checkOutput("detInBit", int'(detIn), int'(protoWord[WORD_W-protoPhase]));
                protoPhase = (protoPhase == WORD_W) ? -1 : protoPhase + 1;
            end
            g = modelBusy ? -1 : pickGrant(reqValid, modelPtr);
            expReady = (g >= 0) ? (1 << g) : 0;
            checkOutput("reqReady", int'(reqReady), expReady);
            if (g >= 0 && int'(reqReady) == expReady) begin
                grantWord = reqData[g*WORD_W +: WORD_W];
                e.id = g;
                e.count = pairCount(grantWord);
                expQ.push_back(e);
                modelBusy  = 1'b1;
                grantCycle = cycleCount;
                protoWord  = grantWord;
                protoPhase = 0;
            end
            if (rspValid) begin
                if (expQ.size() == 0) begin
                    checkOutput("rspUnexpected", int'(rspValid), 0);
                end else begin
                    if (!prevHold) begin
                        checkOutput("rspLatency", cycleCount - grantCycle, WORD_W + 3);
                    end else begin
                        checkOutput("rspIdStable", int'(rspId), prevId);
                        checkOutput("rspCountStable", int'(rspCount), prevCount);
                    end
                    if (rspReady) begin
                        e = expQ.pop_front();
                        checkOutput("rspId", int'(rspId), e.id);
                        checkOutput("rspCount", int'(rspCount), e.count);
                        modelPtr  = e.id;
                        modelBusy = 1'b0;
                        prevHold  = 1'b0;
                    end else begin
                        prevHold  = 1'b1;
                        prevId    = int'(rspId);
                        prevCount = int'(rspCount);
                    end
                end
            end else begin
                if (prevHold) begin
                    checkOutput("rspHeld", int'(rspValid), 1);
                    prevHold = 1'b0;
                end
                if (modelBusy && cycleCount - grantCycle == WORD_W + 4)
                    checkOutput("rspMissing", int'(rspValid), 1);
            end
        end
    end

    // One cycle of stimulus time; granted requesters drop (or refill when keepAll is set).
    bit keepAll = 1'b0;
    task automatic tick(output logic [NREQ-1:0] got);
        @(negedge clk);
        got = reqReady;
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (got[i]) begin
                if (keepAll) reqData[i*WORD_W +: WORD_W] = WORD_W'($urandom);
                else reqValid[i] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input int id, input logic [WORD_W-1:0] word);
        reqData[id*WORD_W +: WORD_W] = word;
        reqValid[id] = 1'b1;
    endtask

    task automatic waitIdle(input int budget);
        logic [NREQ-1:0] got;
        for (int c = 0; c < budget; c++) begin
            if (reqValid == '0 && !modelBusy && expQ.size() == 0) return;
            tick(got);
        end
        $display("[TB] wait budget expired (cycle %0d)", cycleCount);
    endtask

    task automatic doReset();
        logic [NREQ-1:0] got;
        reset = 1'b1;
        reqValid = '0;
        repeat (2) tick(got);
        reset = 1'b0;
    endtask

    logic [NREQ-1:0] got;
    logic [WORD_W-1:0] extremes [4];
    int grants;

    initial begin
        reset    = 1'b1;
        reqValid = '0;
        reqData  = '0;
        rspReady = 1'b1;
        extremes[0] = 8'hFF;
        extremes[1] = 8'h00;
        extremes[2] = 8'h55;
        extremes[3] = 8'hAA;
        doReset();

        $display("[TB] single request");
        applyStimulus(0, 8'b0011_0110);
        waitIdle(100);

        $display("[TB] extreme words");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, extremes[k]);
            waitIdle(100);
        end

        $display("[TB] all requesters held high");
        doReset();
        keepAll = 1'b1;
        for (int i = 0; i < NREQ; i++) applyStimulus(i, WORD_W'($urandom));
        grants = 0;
        for (int c = 0; c < 300 && grants < 5; c++) begin
            tick(got);
            if (got != '0) grants++;
        end
        keepAll = 1'b0;
        reqValid = '0;
        waitIdle(100);

        $display("[TB] response backpressure");
        rspReady = 1'b0;
        applyStimulus(1, WORD_W'($urandom));
        for (int c = 0; c < 50 && !rspValid; c++) tick(got);
        applyStimulus(2, WORD_W'($urandom));
        repeat (5) tick(got);
        rspReady = 1'b1;
        waitIdle(100);

        $display("[TB] reset during shift");
        applyStimulus(3, WORD_W'($urandom));
        got = '0;
        for (int c = 0; c < 50 && !got[3]; c++) tick(got);
        repeat (5) tick(got);
        reset = 1'b1;
        tick(got);
        reset = 1'b0;
        applyStimulus(3, WORD_W'($urandom));
        applyStimulus(0, WORD_W'($urandom));
        waitIdle(100);

        $display("[TB] random traffic");
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!reqValid[i] && $urandom_range(0, 4) == 0) applyStimulus(i, WORD_W'($urandom));
                else if (reqValid[i] && $urandom_range(0, 60) == 0) reqValid[i] = 1'b0;
            end
            rspReady = ($urandom_range(0, 2) != 0);
            tick(got);
        end
        rspReady = 1'b1;
        waitIdle(300);

        @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pair_det_sched.md
Name: pair_det_sched

Overview:
- Round-robin scheduler that shares one external pair detector among NREQ requesters.
- The pair detector is the 1-bit Moore machine: out=1 when its last two sampled bits are 00 or 11. Its reset is synchronous, and it samples one bit per clk.
- For each granted request, this block clears the detector, serialises a WORD_W-bit word into it MSB-first, and counts cycles with det_out=1.
- It returns {requester id, pair count} on a valid/ready response port.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WORD_W, 8, bits per request word (>=2)
- CNT_W, 4, width of the pair count; must hold WORD_W-1
- ID_W, 2, width of rsp_id; must equal clog2(NREQ)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- req_valid  in  NREQ  per-requester request pending
- req_data  in  NREQ*WORD_W  request word; requester i uses slice [i*WORD_W +: WORD_W]
- req_ready  out  NREQ  one-hot, 1-cycle accept pulse
- det_rst  out  1  reset to the pair detector
- det_in  out  1  serial bit to the pair detector
- det_out  in  1  pair detector Moore output
- rsp_valid  out  1  result available
- rsp_id  out  ID_W  index of the requester served
- rsp_count  out  CNT_W  number of pairs detected in the word
- rsp_ready  in  1  consumer accepts result

Behaviour:
- Reset values: req_ready=0, det_in=0, rsp_valid=0, rsp_id=0, rsp_count=0, state=IDLE, rr_ptr=NREQ-1 (requester 0 wins first).
- det_rst = reset OR (state==CLR). It is combinational, so the detector is cleared whenever this block is in reset.
- FSM states: IDLE, CLR, SHIFT, DRAIN, RESP.
- IDLE:
  - If any req_valid is set, grant the first valid index searching upward from rr_ptr+1, with modulo-NREQ wrap.
  - In that same cycle, pulse req_ready[g]=1, latch req_data slice into shreg, latch g into id_reg, clear cnt, and go to CLR.
  - With no request, stay in IDLE, with req_ready=0.
- CLR: one cycle, det_rst=1, det_in=0; go to SHIFT with bit index idx=0.
- SHIFT:
  - Lasts WORD_W cycles.
  - det_in = shreg[WORD_W-1-idx] (MSB first), and idx increments each cycle.
  - cnt += det_out in every SHIFT cycle. det_out during SHIFT cycle i reflects bits 0..i-1.
  - After idx=WORD_W-1, go to DRAIN.
- DRAIN:
  - One cycle, det_in=0 (not sampled for counting).
  - cnt += det_out, which reflects bits up to WORD_W-1.
  - Go to RESP and load rsp_count=final cnt and rsp_id=id_reg.
- RESP:
  - rsp_valid=1; rsp_id and rsp_count are held stable until rsp_ready=1.
  - On the handshake cycle: rr_ptr=id_reg, rsp_valid drops next cycle, go to IDLE.
  - New requests are not granted while in CLR, SHIFT, DRAIN or RESP.
- Overlapping pairs all count: 000 counts 2. Maximum count is WORD_W-1, so there is no overflow if CNT_W is sized per parameter rule.
- Latency: rsp_valid rises WORD_W+3 cycles after the req_ready pulse cycle (11 cycles for WORD_W=8). Minimum spacing between grants is WORD_W+4 cycles.
- Requesters must hold req_valid and req_data until they see req_ready. Deasserting before the grant is legal, and the request is simply not served.
- Reset mid-operation (any state):
  - The next cycle is IDLE with reset values; any in-flight word and count are discarded and no response is issued.
  - rr_ptr returns to NREQ-1.
- rsp_ready while rsp_valid=0 is ignored.

Optional Feature:
- PAIR_DET_SCHED_PRIO_EN defined: fixed priority. The lowest-index valid requester is always granted, and rr_ptr is unused.
- Not defined: round-robin as specified above.
- Everything else is identical: latency, handshakes and counting.

Test Plan:
- Single request: reset, then req_valid=4'b0001 with data 8'b0011_0110 -> req_ready=4'b0001 for 1 cycle; 11 cycles later rsp_valid=1, rsp_id=0, rsp_count=3.
- Extremes, each issued after the previous response is accepted:
  - 8'hFF -> rsp_count=7
  - 8'h00 -> rsp_count=7
  - 8'h55 -> rsp_count=0
  - 8'hAA -> rsp_count=0
- Round-robin: all four req_valid held high with rsp_ready=1 -> grants in order 0,1,2,3,0. With PAIR_DET_SCHED_PRIO_EN, requester 0 is granted every time.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_count are stable; no req_ready pulse occurs; the next grant arrives 1 cycle after the handshake.
- Reset mid-SHIFT: assert reset at idx=4 -> next cycle IDLE, rsp_valid=0, det_rst=1 during reset, no response for the aborted word; the following request is served by requester 0 first.
- Detector protocol check: monitor det_rst high for exactly one cycle before each burst of 8 det_in bits, and det_in equal to the word MSB-first.
